// File: rtl/keccak_p1600_round_ctrl.sv
// ----------------------------------------------------------------------------
// keccak_p1600_round_ctrl
//
// Control end of a one-round-per-cycle Keccak-p[1600] datapath. Takes a
// 1600-bit state on a valid/ready input handshake, loads it into the
// datapath and then steps the datapath through NUM_ROUNDS rounds, starting
// at round index FIRST_ROUND. The last round is read combinationally from
// the datapath, captured into the output register and presented on a
// valid/ready output handshake.
//
// Parameters
//   NUM_ROUNDS   rounds applied (2..24)
//   FIRST_ROUND  index of the first round; FIRST_ROUND+NUM_ROUNDS <= 24
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_in_valid/o_in_ready     input handshake
//   i_in_mode, i_in_state     lane ordering mode and state to permute
//   o_out_valid/i_out_ready   output handshake
//   o_out_state               permuted state, held until accepted
//   o_busy                    core FSM not idle
//   o_dp_enable               datapath register enable
//   o_dp_sel_input            0 = load o_dp_state, 1 = feed back round output
//   o_dp_mode                 datapath lane ordering mode
//   o_dp_round_number         datapath round constant index
//   o_dp_state                datapath input state (copy of i_in_state)
//   i_dp_state                datapath round output
//
// Configuration macro
//   KECCAK_ROUND_CTRL_OVERLAP_EN
//     undefined: a new state is accepted only once the held result is gone.
//     defined:   a new permutation may run while the previous result waits;
//                FINAL then stalls until the output slot frees up.
// ----------------------------------------------------------------------------
module keccak_p1600_round_ctrl #(
    parameter int NUM_ROUNDS  = 24,
    parameter int FIRST_ROUND = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic          i_in_mode,
    input  logic [1599:0] i_in_state,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [1599:0] o_out_state,
    output logic          o_busy,
    output logic          o_dp_enable,
    output logic          o_dp_sel_input,
    output logic          o_dp_mode,
    output logic [4:0]    o_dp_round_number,
    output logic [1599:0] o_dp_state,
    input  logic [1599:0] i_dp_state
);

    // state | meaning
    // IDLE  | waiting for an input handshake; datapath loads on that edge
    // ROUND | datapath register feeds back, one round applied per edge
    // FINAL | datapath output is the last round; capture when slot is free

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_e;

    localparam logic [4:0] FIRST_RN = 5'(FIRST_ROUND);
    localparam logic [4:0] LAST_K   = 5'(NUM_ROUNDS - 2);
    localparam logic [4:0] LAST_RN  = 5'(FIRST_ROUND + NUM_ROUNDS - 1);

    state_e          state_q, state_d;
    logic [4:0]      k_q, k_d;
    logic            mode_q, mode_d;
    logic            out_valid_q, out_valid_d;
    logic [1599:0]   out_state_q, out_state_d;

    logic            in_ready;
    logic            in_hs;
    logic            capture;

    always_comb begin
`ifdef KECCAK_ROUND_CTRL_OVERLAP_EN
        in_ready = (state_q == ST_IDLE);
`else
        in_ready = (state_q == ST_IDLE) & ~out_valid_q;
`endif
        in_hs   = i_in_valid & in_ready;
        capture = (state_q == ST_FINAL) & (~out_valid_q | i_out_ready);

        state_d           = state_q;
        k_d               = k_q;
        mode_d            = mode_q;
        o_dp_enable       = 1'b0;
        o_dp_sel_input    = 1'b0;
        o_dp_mode         = mode_q;
        o_dp_round_number = 5'd0;

        case (state_q)
            ST_IDLE: begin
                o_dp_enable = in_hs;
                o_dp_mode   = i_in_mode;
                if (in_hs) begin
                    mode_d  = i_in_mode;
                    k_d     = 5'd0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                o_dp_enable       = 1'b1;
                o_dp_sel_input    = 1'b1;
                o_dp_round_number = FIRST_RN + k_q;
                k_d               = k_q + 5'd1;
                if (k_q == LAST_K) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                // Register is not clocked here; the datapath's combinational
                // output with the last round constant is the result.
                o_dp_sel_input    = 1'b1;
                o_dp_round_number = LAST_RN;
                if (capture) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A capture in the same cycle as a consumer accept refills the slot.
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        if (capture) begin
            out_valid_d = 1'b1;
            out_state_d = i_dp_state;
        end else if (out_valid_q & i_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= 5'd0;
            mode_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
        end
    end

    assign o_in_ready  = in_ready;
    assign o_out_valid = out_valid_q;
    assign o_out_state = out_state_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_dp_state  = i_in_state;

endmodule
